// File: rtl/armleocpu_regfile_issue_pkg.sv
// rtl/armleocpu_regfile_issue_pkg.sv - register-file widths, captured-operand type and helpers
package armleocpu_regfile_issue_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_X0 = 5'd0;

    typedef struct packed {
        logic  live;
        logic  byp;
        xlen_t data;
    } operand_t;

    function automatic operand_t operand_capture(input logic used, input reg_addr_t addr,
                                                 input logic byp_hit, input xlen_t byp_data);
        operand_t op;
        op.live = used && (addr != REG_X0);
        op.byp  = op.live && byp_hit;
        op.data = op.byp ? byp_data : '0;
        return op;
    endfunction

    // The regfile only returns pre-write data, so a captured writeback value overrides it.
    function automatic xlen_t operand_value(input operand_t op, input xlen_t rdata);
        if (!op.live) begin
            return '0;
        end
        return op.byp ? op.data : rdata;
    endfunction
endpackage

// File: rtl/armleocpu_regfile_issue_if.sv
// rtl/armleocpu_regfile_issue_if.sv - decode, regfile, execute and writeback signals of the issue stage
interface armleocpu_regfile_issue_if;
    import armleocpu_regfile_issue_pkg::*;

    logic      d2i_valid;
    logic      d2i_ready;
    logic      d2i_rs1_use;
    reg_addr_t d2i_rs1_addr;
    logic      d2i_rs2_use;
    reg_addr_t d2i_rs2_addr;
    logic      d2i_rd_write;
    reg_addr_t d2i_rd_addr;
    logic      rs1_read;
    reg_addr_t rs1_addr;
    xlen_t     rs1_rdata;
    logic      rs2_read;
    reg_addr_t rs2_addr;
    xlen_t     rs2_rdata;
    logic      rd_write;
    reg_addr_t rd_addr;
    xlen_t     rd_wdata;
    logic      i2e_valid;
    logic      i2e_ready;
    xlen_t     i2e_rs1_data;
    xlen_t     i2e_rs2_data;
    logic      i2e_rd_write;
    reg_addr_t i2e_rd_addr;
    logic      wb_valid;
    reg_addr_t wb_rd_addr;
    xlen_t     wb_rd_wdata;
    logic      flush;

    modport slave (
        input  d2i_valid, d2i_rs1_use, d2i_rs1_addr, d2i_rs2_use, d2i_rs2_addr,
               d2i_rd_write, d2i_rd_addr, rs1_rdata, rs2_rdata, i2e_ready,
               wb_valid, wb_rd_addr, wb_rd_wdata, flush,
        output d2i_ready, rs1_read, rs1_addr, rs2_read, rs2_addr, rd_write, rd_addr,
               rd_wdata, i2e_valid, i2e_rs1_data, i2e_rs2_data, i2e_rd_write, i2e_rd_addr
    );

    modport master (
        output d2i_valid, d2i_rs1_use, d2i_rs1_addr, d2i_rs2_use, d2i_rs2_addr,
               d2i_rd_write, d2i_rd_addr, rs1_rdata, rs2_rdata, i2e_ready,
               wb_valid, wb_rd_addr, wb_rd_wdata, flush,
        input  d2i_ready, rs1_read, rs1_addr, rs2_read, rs2_addr, rd_write, rd_addr,
               rd_wdata, i2e_valid, i2e_rs1_data, i2e_rs2_data, i2e_rd_write, i2e_rd_addr
    );
endinterface

// File: rtl/armleocpu_scoreboard.sv
// rtl/armleocpu_scoreboard.sv - in-flight destination bits with set-wins priority and pending lookup
module armleocpu_scoreboard
    import armleocpu_regfile_issue_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_i,
    input  reg_addr_t             set_addr_i,
    input  logic                  clr_i,
    input  reg_addr_t             clr_addr_i,
    input  logic                  kill_i,
    input  reg_addr_t             kill_addr_i,
    input  reg_addr_t [2:0]       look_addr_i,
    output logic      [2:0]       pend_o
);
    logic [REG_COUNT-1:0] sb_q;
    logic [REG_COUNT-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_i) begin
            sb_d[clr_addr_i] = 1'b0;
        end
        if (kill_i) begin
            sb_d[kill_addr_i] = 1'b0;
        end
        if (set_i) begin
            sb_d[set_addr_i] = 1'b1;
        end
        sb_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // A same-cycle writeback hides the bit only when its data can be bypassed.
    always_comb begin
        pend_o = '0;
        for (int i = 0; i < 3; i++) begin
            pend_o[i] = sb_q[look_addr_i[i]] &&
                        !(BYPASS_EN && clr_i && (clr_addr_i == look_addr_i[i]));
        end
    end
endmodule

// File: rtl/armleocpu_regfile_issue.sv
// rtl/armleocpu_regfile_issue.sv - issue stage: hazard check, regfile read/write, operand bypass to execute
module armleocpu_regfile_issue
    import armleocpu_regfile_issue_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input logic                        clk,
    input logic                        rst,
    armleocpu_regfile_issue_if.slave   bus
);
    logic      i2e_valid_q, i2e_valid_d;
    logic      i2e_rd_write_q, i2e_rd_write_d;
    reg_addr_t i2e_rd_addr_q, i2e_rd_addr_d;
    operand_t  op1_q, op1_d;
    operand_t  op2_q, op2_d;

    logic [2:0] pend;
    logic       hazard, slot_free, ready, accept;
    logic       sb_set, sb_kill, byp1_hit, byp2_hit;

    assign sb_set  = accept && bus.d2i_rd_write && (bus.d2i_rd_addr != REG_X0);
    assign sb_kill = bus.flush && i2e_valid_q && i2e_rd_write_q;

    armleocpu_scoreboard #(.BYPASS_EN(BYPASS_EN)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_i       (sb_set),
        .set_addr_i  (bus.d2i_rd_addr),
        .clr_i       (bus.wb_valid),
        .clr_addr_i  (bus.wb_rd_addr),
        .kill_i      (sb_kill),
        .kill_addr_i (i2e_rd_addr_q),
        .look_addr_i ({bus.d2i_rd_addr, bus.d2i_rs2_addr, bus.d2i_rs1_addr}),
        .pend_o      (pend)
    );

    always_comb begin
        hazard    = (bus.d2i_rs1_use && pend[0]) ||
                    (bus.d2i_rs2_use && pend[1]) ||
                    (bus.d2i_rd_write && (bus.d2i_rd_addr != REG_X0) && pend[2]);
        slot_free = !i2e_valid_q || bus.i2e_ready;
        ready     = slot_free && !hazard && !bus.flush && !rst;
        accept    = bus.d2i_valid && ready;
    end

    assign byp1_hit = BYPASS_EN && bus.wb_valid && (bus.wb_rd_addr == bus.d2i_rs1_addr);
    assign byp2_hit = BYPASS_EN && bus.wb_valid && (bus.wb_rd_addr == bus.d2i_rs2_addr);

    always_comb begin
        i2e_valid_d    = i2e_valid_q;
        i2e_rd_write_d = i2e_rd_write_q;
        i2e_rd_addr_d  = i2e_rd_addr_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        if (bus.flush) begin
            i2e_valid_d    = 1'b0;
            i2e_rd_write_d = 1'b0;
        end else if (accept) begin
            i2e_valid_d    = 1'b1;
            i2e_rd_write_d = bus.d2i_rd_write;
            i2e_rd_addr_d  = bus.d2i_rd_addr;
            op1_d = operand_capture(bus.d2i_rs1_use, bus.d2i_rs1_addr, byp1_hit, bus.wb_rd_wdata);
            op2_d = operand_capture(bus.d2i_rs2_use, bus.d2i_rs2_addr, byp2_hit, bus.wb_rd_wdata);
        end else if (bus.i2e_ready) begin
            i2e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i2e_valid_q    <= 1'b0;
            i2e_rd_write_q <= 1'b0;
            i2e_rd_addr_q  <= REG_X0;
            op1_q          <= '0;
            op2_q          <= '0;
        end else begin
            i2e_valid_q    <= i2e_valid_d;
            i2e_rd_write_q <= i2e_rd_write_d;
            i2e_rd_addr_q  <= i2e_rd_addr_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
        end
    end

    assign bus.d2i_ready    = ready;
    assign bus.rs1_read     = accept && bus.d2i_rs1_use;
    assign bus.rs1_addr     = bus.d2i_rs1_addr;
    assign bus.rs2_read     = accept && bus.d2i_rs2_use;
    assign bus.rs2_addr     = bus.d2i_rs2_addr;
    assign bus.rd_write     = bus.wb_valid && (bus.wb_rd_addr != REG_X0) && !rst;
    assign bus.rd_addr      = bus.wb_rd_addr;
    assign bus.rd_wdata     = bus.wb_rd_wdata;
    assign bus.i2e_valid    = i2e_valid_q;
    assign bus.i2e_rd_write = i2e_rd_write_q;
    assign bus.i2e_rd_addr  = i2e_rd_addr_q;
    assign bus.i2e_rs1_data = operand_value(op1_q, bus.rs1_rdata);
    assign bus.i2e_rs2_data = operand_value(op2_q, bus.rs2_rdata);
endmodule
